// File: rtl/lvds_rx_deser_pkg.sv
// ----------------------------------------------------------------------------
// lvds_pkg
//   Definitions shared by the LVDS dibit TX serializer and RX deserializer:
//   FSM state encodings, default sync dibits and word geometry.
// ----------------------------------------------------------------------------
package lvds_pkg;

    // RX framing FSM states. Encoding 2'd3 is never entered on purpose; the
    // FSM recovers from it to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_I_PHASE = 2'd1,
        ST_Q_PHASE = 2'd2,
        ST_UNUSED  = 2'd3
    } state_e;

    // Sync dibits: I-sync sits at word bits [31:30], Q-sync at bits [15:14].
    localparam logic [1:0] SYNC_I_DEF = 2'b10;
    localparam logic [1:0] SYNC_Q_DEF = 2'b01;

    // One 32-bit I/Q word is carried as 16 dibits, MSB-first.
    localparam int DIBITS_PER_WORD = 16;
    // Dibit index at which the Q-sync pattern is expected.
    localparam int Q_SYNC_IDX      = 8;
    localparam int DIBIT_IDX_W     = $clog2(DIBITS_PER_WORD);

endpackage

// File: rtl/lvds_rx_deser_if.sv
// ----------------------------------------------------------------------------
// lvds_rx_deser_if
//   Write side of the RX FIFO.
//     fifo_write_clk : FIFO write clock (the dibit clock)
//     fifo_push      : one-cycle write strobe
//     fifo_data      : 32-bit word to write
//     fifo_full      : FIFO full flag back to the writer
//   master = deserializer (writer), slave = FIFO.
// ----------------------------------------------------------------------------
interface lvds_rx_deser_if;

    logic        fifo_write_clk;
    logic        fifo_push;
    logic [31:0] fifo_data;
    logic        fifo_full;

    modport master (
        output fifo_write_clk,
        output fifo_push,
        output fifo_data,
        input  fifo_full
    );

    modport slave (
        input  fifo_write_clk,
        input  fifo_push,
        input  fifo_data,
        output fifo_full
    );

endinterface

// File: rtl/lvds_rx_deser_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   Width-parameterised up-counter that saturates at all-ones.
//     i_clk   : clock, rising edge
//     i_rst   : synchronous reset, active-high
//     i_clear : synchronous clear; wins over a simultaneous increment
//     i_inc   : count one event
//     o_count : current count
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] count_q;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else if (i_clear) begin
            count_q <= '0;
        end else if (i_inc && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/lvds_rx_deser.sv
// ----------------------------------------------------------------------------
// lvds_rx_deser
//   Frames the 2-bit-per-clock LVDS RX dibit stream into 32-bit I/Q words,
//   keyed on the I-sync (bits 31:30) and Q-sync (bits 15:14) patterns, and
//   pushes each complete word into the RX FIFO. Bit 0 of every pushed word
//   carries the external timing marker instead of the received bit.
//     i_ddr_clk      : dibit clock, rising edge
//     i_rst          : synchronous reset, active-high
//     i_ddr_data     : captured dibit, MSB-first within a word
//     i_rx_state     : receive enable; 0 forces IDLE and suppresses pushes
//     i_sync_input   : timing marker inserted into word bit 0
//     i_clear_status : clears o_overflow and o_err_count
//     fifo_if        : RX FIFO write port (write clock, push, data, full)
//     o_overflow     : sticky, a word was dropped on a full FIFO
//     o_err_count    : saturating count of Q-sync mismatches
//     o_debug_state  : current FSM state encoding
// ----------------------------------------------------------------------------
module lvds_rx_deser
    import lvds_pkg::*;
#(
    parameter logic [1:0] SYNC_I    = SYNC_I_DEF,
    parameter logic [1:0] SYNC_Q    = SYNC_Q_DEF,
    parameter int         ERR_CNT_W = 8
) (
    input  logic                 i_ddr_clk,
    input  logic                 i_rst,
    input  logic [1:0]           i_ddr_data,
    input  logic                 i_rx_state,
    input  logic                 i_sync_input,
    input  logic                 i_clear_status,
    lvds_rx_deser_if.master      fifo_if,
    output logic                 o_overflow,
    output logic [ERR_CNT_W-1:0] o_err_count,
    output logic [1:0]           o_debug_state
);

    localparam int               KW      = DIBIT_IDX_W;
    localparam logic [KW-1:0]    K_QSYNC = KW'(Q_SYNC_IDX);
    localparam logic [KW-1:0]    K_LAST  = KW'(DIBITS_PER_WORD - 1);

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    // Only 15 dibits are ever held: the 16th completes the word directly
    // from i_ddr_data on the completion edge.
    logic [29:0]   shift_q, shift_d;
    logic          push_q, push_d;
    logic [31:0]   data_q, data_d;
    logic          overflow_q;
    logic          overflow_set;
    logic          err_inc;

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        shift_d      = shift_q;
        push_d       = 1'b0;
        data_d       = data_q;
        overflow_set = 1'b0;
        err_inc      = 1'b0;

        if (!i_rx_state) begin
            // Receive disabled: abandon any partial word silently.
            state_d = ST_IDLE;
            k_d     = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    k_d = '0;
                    if (i_ddr_data == SYNC_I) begin
                        shift_d = {shift_q[27:0], i_ddr_data};
                        k_d     = KW'(1);
                        state_d = ST_I_PHASE;
                    end
                end

                ST_I_PHASE: begin
                    if (k_q == K_QSYNC) begin
                        if (i_ddr_data == SYNC_Q) begin
                            shift_d = {shift_q[27:0], i_ddr_data};
                            k_d     = k_q + KW'(1);
                            state_d = ST_Q_PHASE;
                        end else begin
                            // Bad Q-sync: drop the frame. The offending
                            // dibit is consumed here, not re-tried as I-sync.
                            k_d     = '0;
                            state_d = ST_IDLE;
                            err_inc = 1'b1;
                        end
                    end else begin
                        shift_d = {shift_q[27:0], i_ddr_data};
                        k_d     = k_q + KW'(1);
                    end
                end

                ST_Q_PHASE: begin
                    shift_d = {shift_q[27:0], i_ddr_data};
                    if (k_q == K_LAST) begin
                        // Word complete; IDLE sees the very next dibit, so
                        // back-to-back words need no gap.
                        k_d     = '0;
                        state_d = ST_IDLE;
                        if (!fifo_if.fifo_full) begin
                            push_d = 1'b1;
                            data_d = {shift_q, i_ddr_data[1], i_sync_input};
                        end else begin
                            overflow_set = 1'b1;
                        end
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end

                default: begin
                    k_d     = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_ddr_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            shift_q    <= '0;
            push_q     <= 1'b0;
            data_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            shift_q <= shift_d;
            push_q  <= push_d;
            data_q  <= data_d;
            // Clear beats a same-cycle overflow event; that event is lost.
            if (i_clear_status) begin
                overflow_q <= 1'b0;
            end else if (overflow_set) begin
                overflow_q <= 1'b1;
            end
        end
    end

    sat_counter #(
        .WIDTH (ERR_CNT_W)
    ) u_err_cnt (
        .i_clk   (i_ddr_clk),
        .i_rst   (i_rst),
        .i_clear (i_clear_status),
        .i_inc   (err_inc),
        .o_count (o_err_count)
    );

    assign fifo_if.fifo_write_clk = i_ddr_clk;
    assign fifo_if.fifo_push      = push_q;
    assign fifo_if.fifo_data      = data_q;
    assign o_overflow             = overflow_q;
    assign o_debug_state          = state_q;

endmodule

// File: tb/tb_lvds_rx_deser.sv
// ----------------------------------------------------------------------------
// tb_lvds_rx_deser
//   Directed bench for lvds_rx_deser. A dibit-list model tracks the
//   expected outputs every cycle; literal expectations pin key results.
// ----------------------------------------------------------------------------
module tb_lvds_rx_deser;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ddr_data;
    logic        rx_state;
    logic        sync_input;
    logic        clear_status;
    logic        overflow;
    logic [7:0]  err_count;
    logic [1:0]  debug_state;

    lvds_rx_deser_if fifo_if ();

    lvds_rx_deser dut (
        .i_ddr_clk      (clk),
        .i_rst          (rst),
        .i_ddr_data     (ddr_data),
        .i_rx_state     (rx_state),
        .i_sync_input   (sync_input),
        .i_clear_status (clear_status),
        .fifo_if        (fifo_if),
        .o_overflow     (overflow),
        .o_err_count    (err_count),
        .o_debug_state  (debug_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: a word is the list of dibits collected since a SYNC_I seen
    // while no word was open. The 9th must be SYNC_Q, the 16th completes.
    // ------------------------------------------------------------------
    logic [1:0]  m_dib [16];
    int          m_n;
    logic        model_valid = 1'b0;
    logic        exp_push;
    logic [31:0] exp_data;
    logic        exp_ovf;
    logic [7:0]  exp_err;

    always @(posedge clk) begin
        int          n;
        logic        bad;
        logic        ovf_ev;
        logic        push;
        logic [31:0] data;
        logic [31:0] word;
        n      = m_n;
        bad    = 1'b0;
        ovf_ev = 1'b0;
        push   = 1'b0;
        data   = exp_data;
        word   = '0;
        if (rst) begin
            model_valid <= 1'b1;
            m_n         <= 0;
            exp_push    <= 1'b0;
            exp_data    <= '0;
            exp_ovf     <= 1'b0;
            exp_err     <= '0;
        end else begin
            if (!rx_state) begin
                n = 0;
            end else if (n == 0) begin
                if (ddr_data == 2'b10) begin
                    m_dib[0] <= ddr_data;
                    n = 1;
                end
            end else begin
                m_dib[n] <= ddr_data;
                n = n + 1;
                if (n == 9 && ddr_data != 2'b01) begin
                    n   = 0;
                    bad = 1'b1;
                end else if (n == 16) begin
                    for (int i = 0; i < 15; i++) word[31-2*i -: 2] = m_dib[i];
                    word[1:0] = ddr_data;
                    n = 0;
                    if (!fifo_if.fifo_full) begin
                        push = 1'b1;
                        data = {word[31:1], sync_input};
                    end else begin
                        ovf_ev = 1'b1;
                    end
                end
            end
            m_n      <= n;
            exp_push <= push;
            exp_data <= data;
            if (clear_status) begin
                exp_ovf <= 1'b0;
                exp_err <= '0;
            end else begin
                if (ovf_ev) exp_ovf <= 1'b1;
                if (bad && exp_err != 8'hFF) exp_err <= exp_err + 8'd1;
            end
        end
    end

    function automatic logic [1:0] model_state(input int n);
        if (n == 0) return 2'd0;
        if (n <= 8) return 2'd1;
        return 2'd2;
    endfunction

    // Cycle-by-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            check("push",     32'(fifo_if.fifo_push), 32'(exp_push));
            check("data",     fifo_if.fifo_data,      exp_data);
            check("overflow", 32'(overflow),          32'(exp_ovf));
            check("err_count",32'(err_count),         32'(exp_err));
            check("state",    32'(debug_state),       32'(model_state(m_n)));
        end
    end

    // Push log for literal checks.
    logic [31:0] push_data [$];
    int          push_cyc  [$];

    always @(negedge clk) begin
        if (fifo_if.fifo_push === 1'b1) begin
            push_data.push_back(fifo_if.fifo_data);
            push_cyc.push_back(cyc);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change on the falling edge.
    // ------------------------------------------------------------------
    task automatic put(input logic [1:0] d);
        @(negedge clk);
        ddr_data = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(2'b00);
    endtask

    task automatic send_dibits(input logic [31:0] w, input int count, output int start);
        start = 0;
        for (int i = 0; i < count; i++) begin
            put(w[31-2*i -: 2]);
            if (i == 0) start = cyc;
        end
    endtask

    initial begin
        int          s0, s1, s2, base, dummy;
        logic [31:0] w;

        rst          = 1'b1;
        ddr_data     = 2'b00;
        rx_state     = 1'b0;
        sync_input   = 1'b0;
        clear_status = 1'b0;
        fifo_if.fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_push",  32'(fifo_if.fifo_push), 32'd0);
        check("rst_data",  fifo_if.fifo_data,      32'd0);
        check("rst_ovf",   32'(overflow),          32'd0);
        check("rst_err",   32'(err_count),         32'd0);
        check("rst_state", 32'(debug_state),       32'd0);
        check("write_clk", 32'(fifo_if.fifo_write_clk), 32'(clk));

        // Single word, marker = 1
        rx_state   = 1'b1;
        sync_input = 1'b1;
        send_dibits(32'h8ABC_5DEF, 16, s0);
        idle(3);
        check("t1_count",   32'(push_data.size()), 32'd1);
        check("t1_data",    push_data[0],          32'h8ABC_5DEF);
        check("t1_latency", 32'(push_cyc[0] - s0), 32'd16);
        check("t1_err",     32'(err_count),        32'd0);

        // Three back-to-back words, marker = 0
        sync_input = 1'b0;
        base = push_data.size();
        send_dibits(32'h8000_4000, 16, s0);
        send_dibits(32'hBFFF_7FFE, 16, s1);
        send_dibits(32'hA5A5_6A5A, 16, s2);
        idle(3);
        check("t2_count", 32'(push_data.size() - base), 32'd3);
        check("t2_d0",    push_data[base],              32'h8000_4000);
        check("t2_d1",    push_data[base+1],            32'hBFFF_7FFE);
        check("t2_d2",    push_data[base+2],            32'hA5A5_6A5A);
        check("t2_c0",    32'(push_cyc[base]   - s0),   32'd16);
        check("t2_c1",    32'(push_cyc[base+1] - s0),   32'd32);
        check("t2_c2",    32'(push_cyc[base+2] - s0),   32'd48);

        // Corrupted Q-sync, then a valid word
        base = push_data.size();
        send_dibits(32'h8ABC_5DEF, 8, dummy);
        put(2'b11);
        put(2'b00);
        check("t3_state", 32'(debug_state), 32'd0);
        idle(2);
        check("t3_err",   32'(err_count),   32'd1);
        check("t3_nopush",32'(push_data.size() - base), 32'd0);
        send_dibits(32'h8000_4000, 16, dummy);
        idle(3);
        check("t3_count", 32'(push_data.size() - base), 32'd1);
        check("t3_data",  push_data[base],              32'h8000_4000);

        // FIFO full at completion, then clear
        base = push_data.size();
        fifo_if.fifo_full = 1'b1;
        send_dibits(32'h8ABC_5DEF, 16, dummy);
        put(2'b00);
        fifo_if.fifo_full = 1'b0;
        check("t4_nopush", 32'(push_data.size() - base), 32'd0);
        check("t4_ovf",    32'(overflow), 32'd1);
        idle(5);
        check("t4_sticky", 32'(overflow), 32'd1);
        clear_status = 1'b1;
        put(2'b00);
        clear_status = 1'b0;
        check("t4_clr_ovf", 32'(overflow),  32'd0);
        check("t4_clr_err", 32'(err_count), 32'd0);

        // Reset at k=10, then resend
        base = push_data.size();
        w = 32'hA5A5_6A5A;
        send_dibits(w, 10, dummy);
        put(w[11:10]);
        rst = 1'b1;
        put(2'b00);
        rst = 1'b0;
        check("t5_data",  fifo_if.fifo_data, 32'd0);
        check("t5_state", 32'(debug_state),  32'd0);
        check("t5_ovf",   32'(overflow),     32'd0);
        idle(1);
        send_dibits(32'hBFFF_7FFE, 16, dummy);
        idle(3);
        check("t5_count", 32'(push_data.size() - base), 32'd1);
        check("t5_word",  push_data[base],              32'hBFFF_7FFE);

        // Receive disabled at k=12
        base = push_data.size();
        w = 32'h8ABC_5DEF;
        send_dibits(w, 12, dummy);
        put(w[7:6]);
        rx_state = 1'b0;
        put(w[5:4]);
        check("t6_state", 32'(debug_state), 32'd0);
        put(w[3:2]);
        put(w[1:0]);
        idle(2);
        rx_state = 1'b1;
        idle(2);
        check("t6_nopush", 32'(push_data.size() - base), 32'd0);
        check("t6_err",    32'(err_count), 32'd0);

        // Clear coinciding with a Q-sync error: clear wins
        put(2'b10);
        idle(7);
        put(2'b11);
        clear_status = 1'b1;
        put(2'b00);
        clear_status = 1'b0;
        idle(1);
        check("t7_clr_prio", 32'(err_count), 32'd0);

        // 300 bad frames saturate the error counter
        for (int f = 0; f < 300; f++) begin
            put(2'b10);
            idle(7);
            put(2'b11);
        end
        idle(2);
        check("t8_sat",     32'(err_count), 32'd255);
        check("t8_nopush",  32'(push_data.size() - base), 32'd0);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
